// File: rtl/dram_arbiter_if.sv
// Bus bundle between the CPU/VGA requesters, the DRAM controller and the arbiter.
// Handshakes: cpu_req/vga_req are levels held until a one-cycle ack; dram_refresh_data starts an access and dram_data_ready reports the controller idle/done.
interface dram_arbiter_if;
  logic        cpu_req;
  logic        cpu_write_en;
  logic [24:0] cpu_addr;
  logic [15:0] cpu_data_in;
  logic        cpu_ack;
  logic [15:0] cpu_read_data;
  logic        vga_req;
  logic [24:0] vga_addr;
  logic        vga_ack;
  logic        dram_data_ready;
  logic [15:0] dram_read_data;
  logic        dram_refresh_data;
  logic [24:0] dram_addr;
  logic        dram_write_en;
  logic        dram_burst_en;
  logic [15:0] dram_data_in;
  logic        timeout_err;
  logic [2:0]  fsm_state;

  modport master (
    output cpu_req, cpu_write_en, cpu_addr, cpu_data_in,
    output vga_req, vga_addr,
    output dram_data_ready, dram_read_data,
    input  cpu_ack, cpu_read_data, vga_ack,
    input  dram_refresh_data, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
    input  timeout_err, fsm_state
  );

  modport slave (
    input  cpu_req, cpu_write_en, cpu_addr, cpu_data_in,
    input  vga_req, vga_addr,
    input  dram_data_ready, dram_read_data,
    output cpu_ack, cpu_read_data, vga_ack,
    output dram_refresh_data, dram_addr, dram_write_en, dram_burst_en, dram_data_in,
    output timeout_err, fsm_state
  );
endinterface

// File: rtl/dram_arbiter.sv
// Arbitrates CPU word accesses and VGA 32-word burst reads onto one DRAM controller.
// Build option DRAM_ARB_VGA_PRIO_EN: VGA wins every tie; otherwise ties alternate round-robin.
module dram_arbiter (
  input logic           clk,
  input logic           rst,
  dram_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic       OWN_CPU    = 1'b0;
  localparam logic       OWN_VGA    = 1'b1;
  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  logic [2:0]  state;
  logic        owner;
  logic [7:0]  wait_cnt;
  logic        grant_vga;
  logic        refresh_q;
  logic        write_en_q;
  logic        burst_en_q;
  logic        cpu_ack_q;
  logic        vga_ack_q;
  logic        timeout_q;
  logic [24:0] addr_q;
  logic [15:0] data_in_q;
  logic [15:0] read_data_q;
`ifndef DRAM_ARB_VGA_PRIO_EN
  logic        last_grant;
`endif

  // Owner chosen for a grant taken this cycle; only meaningful in IDLE.
  always_comb begin
    grant_vga = bus.vga_req;
    if (bus.cpu_req && bus.vga_req) begin
`ifdef DRAM_ARB_VGA_PRIO_EN
      grant_vga = OWN_VGA;
`else
      grant_vga = (last_grant == OWN_CPU);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner       <= OWN_CPU;
      wait_cnt    <= 8'd0;
      refresh_q   <= 1'b0;
      write_en_q  <= 1'b0;
      burst_en_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vga_ack_q   <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= 25'd0;
      data_in_q   <= 16'd0;
      read_data_q <= 16'd0;
`ifndef DRAM_ARB_VGA_PRIO_EN
      last_grant  <= OWN_VGA;
`endif
    end else begin
      refresh_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      vga_ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.dram_data_ready && (bus.cpu_req || bus.vga_req)) begin
            state     <= S_ISSUE;
            owner     <= grant_vga;
            refresh_q <= 1'b1;
            wait_cnt  <= 8'd0;
`ifndef DRAM_ARB_VGA_PRIO_EN
            last_grant <= grant_vga;
`endif
            if (grant_vga == OWN_VGA) begin
              addr_q     <= bus.vga_addr;
              write_en_q <= 1'b0;
              burst_en_q <= 1'b1;
            end else begin
              addr_q     <= bus.cpu_addr;
              write_en_q <= bus.cpu_write_en;
              burst_en_q <= 1'b0;
              data_in_q  <= bus.cpu_data_in;
            end
          end
        end
        S_ISSUE: state <= S_SETTLE;
        // The controller may still report ready from the previous access here.
        S_SETTLE: begin
          state    <= S_WAIT;
          wait_cnt <= 8'd0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.dram_data_ready || (wait_cnt == WAIT_LIMIT - 8'd1)) begin
            state     <= S_DONE;
            cpu_ack_q <= (owner == OWN_CPU);
            vga_ack_q <= (owner == OWN_VGA);
            if (!bus.dram_data_ready) begin
              timeout_q <= 1'b1;
            end else if ((owner == OWN_CPU) && !write_en_q) begin
              read_data_q <= bus.dram_read_data;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dram_refresh_data = refresh_q;
  assign bus.dram_addr         = addr_q;
  assign bus.dram_write_en     = write_en_q;
  assign bus.dram_burst_en     = burst_en_q;
  assign bus.dram_data_in      = data_in_q;
  assign bus.cpu_ack           = cpu_ack_q;
  assign bus.vga_ack           = vga_ack_q;
  assign bus.cpu_read_data     = read_data_q;
  assign bus.timeout_err       = timeout_q;
  assign bus.fsm_state         = state;
endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: transaction-level predictor, DRAM controller model, decoupled monitor.
`timescale 1ns/1ps
module tb_dram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dram_arbiter_if bus();
  dram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] cyc;
    logic [24:0] addr;
    logic        we;
    logic        burst;
    logic        chk_data;
    logic [15:0] data;
  } stb_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        vga;
    logic        rd;
    logic        to;
    logic [15:0] rdata;
  } ack_t;

  typedef struct packed {
    logic [31:0] delay;
    logic        stale;
    logic [15:0] rdata;
  } ctl_t;

  stb_t exp_stb_q[$];
  ack_t exp_ack_q[$];
  ctl_t ctl_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int force_delay = -1;
  int force_stale = -1;
  int force_rdata = -1;
  bit ctl_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name, input int val);
    checks++;
    errors++;
    $display("FAIL %s: value %0d (cycle %0d)", name, val, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Predictor: a free arbiter samples requests and ready each cycle; every grant
  // costs ISSUE, SETTLE, the WAIT cycles and DONE, capped by the 255-cycle timeout.
  int   next_free = 0;
  logic last_vga  = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        next_free = cyc + 1;
        last_vga  = 1'b1;
      end else if (cyc >= next_free && bus.dram_data_ready && (bus.cpu_req || bus.vga_req)) begin
        logic own_vga;
        int   d;
        int   ack_cyc;
        ctl_t c;
        stb_t s;
        ack_t a;
        if (bus.cpu_req && bus.vga_req) begin
`ifdef DRAM_ARB_VGA_PRIO_EN
          own_vga = 1'b1;
`else
          own_vga = !last_vga;
`endif
        end else begin
          own_vga = bus.vga_req;
        end
        d         = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
        c.delay   = d;
        c.stale   = (force_stale >= 0) ? force_stale[0] : 1'($urandom_range(0, 1));
        c.rdata   = (force_rdata >= 0) ? force_rdata[15:0] : 16'($urandom);
        ack_cyc   = cyc + 4 + ((d > 254) ? 254 : d);
        s.cyc     = cyc + 1;
        s.addr    = own_vga ? bus.vga_addr : bus.cpu_addr;
        s.we      = own_vga ? 1'b0 : bus.cpu_write_en;
        s.burst   = own_vga;
        s.chk_data = !own_vga && bus.cpu_write_en;
        s.data    = bus.cpu_data_in;
        a.cyc     = ack_cyc;
        a.vga     = own_vga;
        a.rd      = !own_vga && !bus.cpu_write_en;
        a.to      = (d >= 255);
        a.rdata   = c.rdata;
        ctl_q.push_back(c);
        exp_stb_q.push_back(s);
        exp_ack_q.push_back(a);
        next_free = ack_cyc + 1;
        last_vga  = own_vga;
      end
    end
  end

  // DRAM controller model: optional stale ready for two cycles after the strobe,
  // then busy for 'delay' cycles, then ready with the read word.
  ctl_t ctl_cur;
  int   ctl_k = 0;
  bit   ctl_act = 1'b0;
  initial begin
    bus.dram_data_ready = 1'b0;
    bus.dram_read_data  = 16'd0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        ctl_q.delete();
        ctl_act = 1'b0;
        bus.dram_data_ready = 1'b0;
      end else if (bus.dram_refresh_data) begin
        ctl_cur = (ctl_q.size() > 0) ? ctl_q.pop_front() : '0;
        ctl_act = 1'b1;
        ctl_k   = 0;
        bus.dram_data_ready = ctl_cur.stale;
      end else if (ctl_act) begin
        ctl_k++;
        if (ctl_k == 1) begin
          bus.dram_data_ready = ctl_cur.stale;
        end else if (ctl_k >= 2 + int'(ctl_cur.delay)) begin
          bus.dram_data_ready = 1'b1;
          bus.dram_read_data  = ctl_cur.rdata;
          ctl_act = 1'b0;
        end else begin
          bus.dram_data_ready = 1'b0;
        end
      end else begin
        bus.dram_data_ready = !ctl_hold;
      end
    end
  end

  // Monitor: pops expectations when the DUT strobes or acks.
  bit          prev_rst_low = 1'b1;
  logic        exp_to = 1'b0;
  logic [15:0] last_rd = 16'd0;
  bit          rd_known = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst_low) begin
        chk("rst_refresh", bus.dram_refresh_data, 0);
        chk("rst_write_en", bus.dram_write_en, 0);
        chk("rst_burst_en", bus.dram_burst_en, 0);
        chk("rst_cpu_ack", bus.cpu_ack, 0);
        chk("rst_vga_ack", bus.vga_ack, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        chk("rst_addr", bus.dram_addr, 0);
        chk("rst_data_in", bus.dram_data_in, 0);
        chk("rst_read_data", bus.cpu_read_data, 0);
      end else begin
        while (exp_stb_q.size() > 0 && int'(exp_stb_q[0].cyc) < cyc) begin
          flag_fail("missing_strobe", int'(exp_stb_q[0].cyc));
          void'(exp_stb_q.pop_front());
        end
        while (exp_ack_q.size() > 0 && int'(exp_ack_q[0].cyc) < cyc) begin
          flag_fail("missing_ack", int'(exp_ack_q[0].cyc));
          void'(exp_ack_q.pop_front());
        end
        if (bus.dram_refresh_data) begin
          if (exp_stb_q.size() == 0) begin
            flag_fail("unexpected_strobe", cyc);
          end else begin
            stb_t s;
            s = exp_stb_q.pop_front();
            chk("strobe_cycle", cyc, s.cyc);
            chk("strobe_addr", bus.dram_addr, s.addr);
            chk("strobe_write_en", bus.dram_write_en, s.we);
            chk("strobe_burst_en", bus.dram_burst_en, s.burst);
            if (s.chk_data) chk("strobe_data_in", bus.dram_data_in, s.data);
          end
          chk("ack_during_strobe", bus.cpu_ack | bus.vga_ack, 0);
        end
        if (bus.cpu_ack || bus.vga_ack) begin
          chk("ack_overlap", bus.cpu_ack & bus.vga_ack, 0);
          if (exp_ack_q.size() == 0) begin
            flag_fail("unexpected_ack", cyc);
          end else begin
            ack_t a;
            a = exp_ack_q.pop_front();
            chk("ack_cycle", cyc, a.cyc);
            chk("ack_vga", bus.vga_ack, a.vga);
            chk("ack_cpu", bus.cpu_ack, !a.vga);
            if (a.to) exp_to = 1'b1;
            if (a.rd && !a.to) begin
              last_rd  = a.rdata;
              rd_known = 1'b1;
            end else if (a.rd) begin
              rd_known = 1'b0;
            end
          end
        end
        if (rd_known) chk("cpu_read_data", bus.cpu_read_data, last_rd);
        chk("timeout_err", bus.timeout_err, exp_to);
      end
      if (!rst) begin
        exp_stb_q.delete();
        exp_ack_q.delete();
        exp_to   = 1'b0;
        last_rd  = 16'd0;
        rd_known = 1'b1;
      end
      prev_rst_low = !rst;
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic cpu_access(input logic we, input logic [24:0] addr, input logic [15:0] data, output int lat);
    bus.cpu_write_en = we;
    bus.cpu_addr     = addr;
    bus.cpu_data_in  = data;
    bus.cpu_req      = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.cpu_ack && lat < 2000);
    if (!bus.cpu_ack) flag_fail("cpu_ack_wait", lat);
    bus.cpu_req = 1'b0;
  endtask

  task automatic vga_access(input logic [24:0] addr, output int lat);
    bus.vga_addr = addr;
    bus.vga_req  = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.vga_ack && lat < 2000);
    if (!bus.vga_ack) flag_fail("vga_ack_wait", lat);
    bus.vga_req = 1'b0;
  endtask

  task automatic tie_test();
    logic [3:0] got;
    logic [3:0] exp_order;
    int n;
    int k;
    got = 4'd0;
    n = 0;
    k = 0;
    bus.cpu_write_en = 1'b0;
    bus.cpu_addr     = 25'($urandom);
    bus.vga_addr     = 25'($urandom);
    bus.cpu_req      = 1'b1;
    bus.vga_req      = 1'b1;
    while (k < 4 && n < 500) begin
      step();
      n++;
      if (bus.cpu_ack || bus.vga_ack) begin
        got[k] = bus.vga_ack;
        k++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.vga_req = 1'b0;
`ifdef DRAM_ARB_VGA_PRIO_EN
    exp_order = 4'b1111;
`else
    exp_order = 4'b1010;
`endif
    chk("tie_grant_count", k, 4);
    chk("tie_order", got, exp_order);
  endtask

  initial begin
    int lat;
    int n;
    bit saw_stb;
    bus.cpu_req      = 1'b0;
    bus.cpu_write_en = 1'b0;
    bus.cpu_addr     = 25'd0;
    bus.cpu_data_in  = 16'd0;
    bus.vga_req      = 1'b0;
    bus.vga_addr     = 25'd0;
    step();
    do_reset(2);
    repeat (3) step();

    // Directed CPU read with immediate ready.
    force_delay = 0; force_stale = 0; force_rdata = 16'hBEEF;
    cpu_access(1'b0, 25'h0001234, 16'h1111, lat);
    chk("cpu_read_latency", lat, 4);
    chk("cpu_read_value", bus.cpu_read_data, 16'hBEEF);
    force_rdata = -1;
    step();

    // Directed CPU write; read data must hold.
    force_rdata = 16'h5555;
    cpu_access(1'b1, 25'h000F7FF, 16'hA5A5, lat);
    chk("cpu_write_latency", lat, 4);
    step();
    chk("read_data_after_write", bus.cpu_read_data, 16'hBEEF);
    force_rdata = -1;

    // VGA burst with stale ready through SETTLE.
    force_delay = 3; force_stale = 1;
    vga_access(25'h0880000, lat);
    chk("vga_stale_latency", lat, 7);
    chk("read_data_after_vga", bus.cpu_read_data, 16'hBEEF);
    force_delay = -1; force_stale = -1;
    step();

    // Continuous contention directly after reset.
    do_reset(1);
    step();
    tie_test();
    repeat (8) step();

    // WAIT timeout with ready held low for 300 cycles.
    force_delay = 300; force_stale = 0;
    cpu_access(1'b0, 25'h1ABCDEF, 16'h0, lat);
    chk("timeout_latency", lat, 258);
    chk("timeout_flag_set", bus.timeout_err, 1);
    force_delay = -1; force_stale = -1;
    cpu_access(1'b1, 25'h0000042, 16'h7E7E, lat);
    step();
    chk("timeout_flag_sticky", bus.timeout_err, 1);
    do_reset(1);
    chk("timeout_flag_cleared", bus.timeout_err, 0);
    step();

    // Reset while an access sits in WAIT with ready low.
    force_delay = 50;
    bus.cpu_write_en = 1'b0;
    bus.cpu_addr     = 25'h0123456;
    bus.cpu_req      = 1'b1;
    n = 0;
    while (!bus.dram_refresh_data && n < 100) begin
      step();
      n++;
    end
    if (!bus.dram_refresh_data) flag_fail("reset_test_strobe_wait", n);
    repeat (4) step();
    ctl_hold = 1'b1;
    do_reset(1);
    saw_stb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dram_refresh_data || bus.cpu_ack) saw_stb = 1'b1;
    end
    chk("no_issue_while_not_ready", saw_stb, 0);
    force_delay = 0;
    ctl_hold = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.cpu_ack && lat < 200);
    chk("post_reset_latency", lat, 4);
    bus.cpu_req = 1'b0;
    force_delay = -1;
    repeat (3) step();

    // Random concurrent traffic.
    fork
      begin
        int l;
        for (int i = 0; i < 25; i++) begin
          cpu_access(1'($urandom_range(0, 1)), 25'($urandom), 16'($urandom), l);
          repeat ($urandom_range(0, 3)) step();
        end
      end
      begin
        int l;
        for (int i = 0; i < 25; i++) begin
          vga_access(25'($urandom), l);
          repeat ($urandom_range(0, 3)) step();
        end
      end
    join

    repeat (20) step();
    chk("stb_queue_drained", exp_stb_q.size(), 0);
    chk("ack_queue_drained", exp_ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
